// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Provides the per-entry record, the word-alignment mask for memory
// addresses and the pointer width helper used by the queue.
package fetch_pkg;

  // Width of PCs, addresses and instruction words.
  localparam int unsigned FETCH_W = 32;

  // Instruction memory is word addressed; the low two PC bits are cleared.
  localparam logic [FETCH_W-1:0] ADDR_ALIGN_MASK = {{(FETCH_W-2){1'b1}}, 2'b00};

  // One queue slot: PC captured at request time, instruction word captured
  // at response time, and a flag saying the word has arrived.
  typedef struct packed {
    logic [FETCH_W-1:0] pc;
    logic [FETCH_W-1:0] instr;
    logic               filled;
  } fetch_entry_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Purpose : circular store of fetch entries with alloc/fill/head pointers.
// Latency : fill at edge T is visible on o_head_* from T+1 (no bypass).
// Backpressure: none internally; the caller gates alloc/fill/consume.
//
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_alloc / i_alloc_pc       reserve the next slot for a request and record its PC
//   i_fill / i_fill_data       write the oldest unfilled slot with its instruction
//   i_consume                  retire the head slot
//   i_flush                    discard every slot; pointers collapse onto fill
//   o_head_filled/_pc/_instr   head slot contents
//   o_count                    slots allocated and not yet consumed
//   o_outstanding              slots allocated and not yet filled
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_alloc,
  input  logic [FETCH_W-1:0] i_alloc_pc,
  input  logic               i_fill,
  input  logic [FETCH_W-1:0] i_fill_data,
  input  logic               i_consume,
  input  logic               i_flush,
  output logic               o_head_filled,
  output logic [FETCH_W-1:0] o_head_pc,
  output logic [FETCH_W-1:0] o_head_instr,
  output logic [PTR_W-1:0]   o_count,
  output logic [PTR_W-1:0]   o_outstanding
);

  localparam int unsigned IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] r_alloc_ptr;
  logic [PTR_W-1:0] r_fill_ptr;
  logic [PTR_W-1:0] r_head_ptr;
  fetch_entry_t     r_entries [DEPTH];

  logic [IDX_W-1:0] w_alloc_idx;
  logic [IDX_W-1:0] w_fill_idx;
  logic [IDX_W-1:0] w_head_idx;

  assign w_alloc_idx = r_alloc_ptr[IDX_W-1:0];
  assign w_fill_idx  = r_fill_ptr[IDX_W-1:0];
  assign w_head_idx  = r_head_ptr[IDX_W-1:0];

  // The three pointers are always ordered head <= fill <= alloc (modulo
  // wrap), so the alloc, fill and head slots touched in one cycle are
  // distinct whenever the caller respects the full/outstanding gating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else if (i_flush) begin
      // Filled-but-unconsumed words are thrown away along with the
      // unfilled slots; the fill pointer becomes the new empty origin.
      r_alloc_ptr <= r_fill_ptr;
      r_head_ptr  <= r_fill_ptr;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i].filled <= 1'b0;
      end
    end else begin
      if (i_alloc) begin
        r_entries[w_alloc_idx].pc     <= i_alloc_pc;
        r_entries[w_alloc_idx].filled <= 1'b0;
        r_alloc_ptr                   <= r_alloc_ptr + PTR_W'(1);
      end
      if (i_fill) begin
        r_entries[w_fill_idx].instr  <= i_fill_data;
        r_entries[w_fill_idx].filled <= 1'b1;
        r_fill_ptr                   <= r_fill_ptr + PTR_W'(1);
      end
      if (i_consume) begin
        r_entries[w_head_idx].filled <= 1'b0;
        r_head_ptr                   <= r_head_ptr + PTR_W'(1);
      end
    end
  end

  assign o_head_filled = r_entries[w_head_idx].filled;
  assign o_head_pc     = r_entries[w_head_idx].pc;
  assign o_head_instr  = r_entries[w_head_idx].instr;
  assign o_count       = r_alloc_ptr - r_head_ptr;
  assign o_outstanding = r_alloc_ptr - r_fill_ptr;

endmodule

// File: rtl/instr_fetch_queue.sv
// Purpose : fetch stage; requests imem in order at pc_i and buffers PC/instr pairs for decode.
// Latency : accept at T, rsp at >=T+1, instr_valid_o from the edge after the rsp (2 cycles min).
// Backpressure: requests stop when buffered + in-flight + to-be-dropped reaches DEPTH.
//
// Ports:
//   clk, rst                     clock, async active-low reset
//   pc_i                         current PC from the program counter
//   redirect_i                   taken branch/jump: flush; pc_i carries the target next cycle
//   pc_advance_o                 fetch of pc_i accepted this cycle
//   imem_req_valid_o/_ready_i    request handshake, address on imem_req_addr_o
//   imem_rsp_valid_i/_data_i     in-order instruction return, no backpressure
//   instr_valid_o/instr_ready_i  decode handshake, head word on instr_o with its PC
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FETCH_W,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  redirect_i,
  output logic                  pc_advance_o,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [DATA_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  // Held low through reset and the first cycle after release so every
  // output is quiet until the core is running.
  logic             r_active;
  // Responses still owed to requests that a redirect has already discarded.
  logic [PTR_W-1:0] r_drop_cnt;

  logic             w_head_filled;
  logic [FETCH_W-1:0] w_head_pc;
  logic [FETCH_W-1:0] w_head_instr;
  logic [PTR_W-1:0] w_count;
  logic [PTR_W-1:0] w_outstanding;
  logic [PTR_W:0]   w_occupancy;
  logic             w_full;
  logic             w_req_vld;
  logic             w_accept;
  logic             w_instr_vld;
  logic             w_consume;
  logic             w_rsp;
  logic             w_fill;
  logic [PTR_W-1:0] w_pending;
  logic [PTR_W-1:0] w_drop_nxt;

  // Dropped responses still arrive, so they hold a credit just like a
  // live outstanding request does.
  assign w_occupancy = {1'b0, w_count} + {1'b0, r_drop_cnt};
  assign w_full      = (w_occupancy >= (PTR_W+1)'(DEPTH));

  assign w_req_vld   = r_active & ~w_full & ~redirect_i;
  assign w_accept    = w_req_vld & imem_req_ready_i;
  assign w_instr_vld = r_active & w_head_filled & ~redirect_i;
  assign w_consume   = w_instr_vld & instr_ready_i;
  assign w_rsp       = r_active & imem_rsp_valid_i;
  assign w_pending   = r_drop_cnt + w_outstanding;

  // Responses return in order, and every dropped request is older than
  // every live one, so the drop counter drains before any fill happens.
  always_comb begin
    w_drop_nxt = r_drop_cnt;
    w_fill     = 1'b0;
    if (redirect_i) begin
      // All unfilled requests become drops; a response arriving in the
      // redirect cycle is itself the oldest of them and is discarded now.
      if (w_rsp && (w_pending != '0)) begin
        w_drop_nxt = w_pending - PTR_W'(1);
      end else begin
        w_drop_nxt = w_pending;
      end
    end else if (w_rsp) begin
      if (r_drop_cnt != '0) begin
        w_drop_nxt = r_drop_cnt - PTR_W'(1);
      end else if (w_outstanding != '0) begin
        w_fill = 1'b1;
      end
      // A response with nothing outstanding is a protocol error and is ignored.
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active   <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_active   <= 1'b1;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_queue (
    .i_clk         (clk),
    .i_rst_n       (rst),
    .i_alloc       (w_accept),
    .i_alloc_pc    (pc_i),
    .i_fill        (w_fill),
    .i_fill_data   (imem_rsp_data_i),
    .i_consume     (w_consume),
    .i_flush       (redirect_i),
    .o_head_filled (w_head_filled),
    .o_head_pc     (w_head_pc),
    .o_head_instr  (w_head_instr),
    .o_count       (w_count),
    .o_outstanding (w_outstanding)
  );

  assign pc_advance_o     = w_accept;
  assign imem_req_valid_o = w_req_vld;
  assign imem_req_addr_o  = r_active ? (pc_i & ADDR_ALIGN_MASK) : '0;
  assign instr_valid_o    = w_instr_vld;
  assign instr_o          = w_instr_vld ? w_head_instr : '0;
  assign instr_pc_o       = w_instr_vld ? w_head_pc : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Purpose : self-checking bench for instr_fetch_queue with an in-order memory model.
// Latency : expected words are queued when responses are driven, compared at consume.
// Backpressure: request/consume readiness and response gaps driven per test phase.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic        drop;
    logic [31:0] cyc;
  } txn_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        redirect_i;
  logic        pc_advance_o;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  instr_fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_i             (pc_i),
    .redirect_i       (redirect_i),
    .pc_advance_o     (pc_advance_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   acc_cnt     = 0;
  int   cons_cnt    = 0;
  bit   live        = 0;
  bit   lat_chk     = 0;
  bit   mem_en      = 0;
  int   rsp_pct     = 100;
  logic [31:0] bench_pc    = 32'h0;
  logic [31:0] rdr_target  = 32'h0;
  txn_t req_q[$];
  txn_t exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h0050_0093 + addr;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at the falling edge: checks the outputs against the model, then
  // applies to the model whatever the coming rising edge will do.
  task automatic observe();
    txn_t e;
    logic exp_req;
    logic exp_ivld;
    int   occ;
    cyc++;
    occ      = req_q.size() + exp_q.size();
    exp_req  = live && !redirect_i && (occ < DEPTH);
    exp_ivld = live && !redirect_i && (exp_q.size() != 0);
    check("req_vld", imem_req_valid_o, exp_req);
    check("pc_adv", pc_advance_o, exp_req && imem_req_ready_i);
    check("ivld", instr_valid_o, exp_ivld);
    if (exp_req) check("req_addr", imem_req_addr_o, bench_pc & 32'hFFFF_FFFC);
    // Consume before fill: a word arriving this edge is not visible yet.
    if (exp_ivld && instr_ready_i) begin
      e = exp_q.pop_front();
      cons_cnt++;
      check("instr_pc", instr_pc_o, e.pc);
      check("instr", instr_o, mem_word(e.addr));
      if (lat_chk) check("latency", cyc - e.cyc, 2);
    end
    if (imem_rsp_valid_i && req_q.size() != 0) begin
      e = req_q.pop_front();
      if (!e.drop && !redirect_i) exp_q.push_back(e);
    end
    if (exp_req && imem_req_ready_i) begin
      e.pc   = bench_pc;
      e.addr = bench_pc & 32'hFFFF_FFFC;
      e.drop = 1'b0;
      e.cyc  = cyc;
      req_q.push_back(e);
      acc_cnt++;
      bench_pc = bench_pc + 32'd4;
    end
    if (redirect_i) begin
      foreach (req_q[i]) req_q[i].drop = 1'b1;
      exp_q.delete();
      bench_pc = rdr_target;
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    live = rst;
    pc_i = bench_pc;
    if (mem_en && req_q.size() != 0 && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(req_q[0].addr);
    end else begin
      imem_rsp_valid_i = 1'b0;
    end
  endtask

  task automatic drive_rsp();
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = mem_word(req_q[0].addr);
  endtask

  task automatic drain();
    int n;
    n = 0;
    imem_req_ready_i = 1'b0;
    instr_ready_i    = 1'b1;
    redirect_i       = 1'b0;
    mem_en           = 1'b1;
    rsp_pct          = 100;
    while ((req_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check("drain_left", req_q.size() + exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_adv"},  pc_advance_o, 0);
    check({tag, "_rvld"}, imem_req_valid_o, 0);
    check({tag, "_addr"}, imem_req_addr_o, 0);
    check({tag, "_ivld"}, instr_valid_o, 0);
    check({tag, "_ins"},  instr_o, 0);
    check({tag, "_ipc"},  instr_pc_o, 0);
  endtask

  initial begin
    int n;
    rst = 1'b0; redirect_i = 1'b0; imem_req_ready_i = 1'b0; instr_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    bench_pc = 32'h24; pc_i = bench_pc;

    // Reset state and release: quiet for the first cycle, then requesting.
    #2;
    check_all_zero("rst");
    step(); step();
    rst = 1'b1;
    step();
    check("rel_req", imem_req_valid_o, 1);
    check("rel_addr", imem_req_addr_o, 32'h24);

    // Streaming: four fetches back to back, two-cycle fetch-to-decode.
    bench_pc = 32'h0; pc_i = bench_pc;
    mem_en = 1; rsp_pct = 100; instr_ready_i = 1; imem_req_ready_i = 1;
    lat_chk = 1; acc_cnt = 0; cons_cnt = 0;
    for (n = 0; n < 20 && acc_cnt < 4; n++) step();
    imem_req_ready_i = 0;
    drain();
    lat_chk = 0;
    check("stream_cons", cons_cnt, 4);

    // Backpressure: decode stalled, exactly DEPTH accepts; one consume frees one slot.
    instr_ready_i = 0; imem_req_ready_i = 1; acc_cnt = 0;
    repeat (12) step();
    check("bp_acc", acc_cnt, DEPTH);
    check("bp_rvld", imem_req_valid_o, 0);
    check("bp_adv", pc_advance_o, 0);
    instr_ready_i = 1;
    step();
    instr_ready_i = 0; acc_cnt = 0;
    repeat (5) step();
    check("bp_one_more", acc_cnt, 1);
    drain();

    // Flush with two requests in flight; their words must never reach decode.
    mem_en = 0; imem_req_ready_i = 1; instr_ready_i = 1; acc_cnt = 0;
    for (n = 0; n < 10 && acc_cnt < 2; n++) step();
    imem_req_ready_i = 0;
    redirect_i = 1; rdr_target = 32'h100;
    step();
    redirect_i = 0; imem_req_ready_i = 1; mem_en = 1; rsp_pct = 100;
    for (n = 0; n < 30 && !instr_valid_o; n++) step();
    check("flush_vld", instr_valid_o, 1);
    check("flush_pc", instr_pc_o, 32'h100);
    imem_req_ready_i = 0;
    drain();

    // Collision: redirect with a response arriving and decode ready, same cycle.
    mem_en = 0; instr_ready_i = 0; imem_req_ready_i = 1; acc_cnt = 0;
    for (n = 0; n < 10 && acc_cnt < 2; n++) step();
    imem_req_ready_i = 0;
    drive_rsp();
    step();
    check("col_pre_vld", instr_valid_o, 1);
    redirect_i = 1; rdr_target = 32'h300; instr_ready_i = 1;
    drive_rsp();
    #1;
    check("col_ivld", instr_valid_o, 0);
    check("col_adv", pc_advance_o, 0);
    step();
    redirect_i = 0;
    check("col_empty", instr_valid_o, 0);
    step(); step();
    check("col_empty2", instr_valid_o, 0);
    check("col_inflight", req_q.size(), 0);
    drain();

    // Wrap: 3*DEPTH fetches with random gaps on every handshake.
    bench_pc = 32'h1002; pc_i = bench_pc;
    mem_en = 1; rsp_pct = 60; acc_cnt = 0; cons_cnt = 0;
    for (n = 0; n < 400 && cons_cnt < 3*DEPTH; n++) begin
      imem_req_ready_i = (acc_cnt < 3*DEPTH) && ($urandom_range(99) < 60);
      instr_ready_i    = ($urandom_range(99) < 50);
      step();
    end
    drain();
    check("wrap_cons", cons_cnt, 3*DEPTH);

    // Random traffic with occasional redirects.
    rsp_pct = 70;
    for (n = 0; n < 300; n++) begin
      imem_req_ready_i = ($urandom_range(99) < 70);
      instr_ready_i    = ($urandom_range(99) < 60);
      redirect_i       = ($urandom_range(99) < 5);
      rdr_target       = $urandom & 32'h0000_FFFC;
      step();
    end
    drain();

    // Reset mid-stream: outputs drop immediately; fetching restarts cleanly.
    imem_req_ready_i = 1; instr_ready_i = 1; rsp_pct = 80;
    repeat (8) step();
    #2;
    rst = 1'b0; live = 0;
    #1;
    check_all_zero("mid_rst");
    req_q.delete(); exp_q.delete();
    mem_en = 0; imem_rsp_valid_i = 0; imem_req_ready_i = 0; instr_ready_i = 0;
    bench_pc = 32'h2000;
    step(); step();
    rst = 1'b1;
    step();
    check("mr_quiet_rvld", imem_req_valid_o, 1);
    check("mr_addr", imem_req_addr_o, 32'h2000);
    imem_req_ready_i = 1; mem_en = 1; rsp_pct = 100;
    repeat (3) step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
